uart_bus_arbiter: RTL and testbench
===================================

// Module: uart_bus_arbiter
// PURPOSE
//  Shares the 16-bit internal register-file bus (int_address/int_wr_data/int_write/int_read/int_rd_data)
//  between two bus masters: master 0 (UART parser side) and master 1 (local controller).
//  Each master issues single read/write transactions over a req/ack handshake.
//  The block arbitrates round-robin, drives one bus cycle, and returns read data with a one-cycle ack.
// PARAMETERS
//  AW          16  address width
//  DW          8   data width
//  RD_LATENCY  1   cycles from int_read high to int_rd_data valid; legal range 1..15
// PORTS
//  clock        in   1   global clock, all logic on rising edge
//  reset        in   1   global reset, asynchronous, active-high
//  m0_req       in   1   master 0 transaction request, held until m0_ack
//  m0_write     in   1   master 0: 1 = write, 0 = read (valid with m0_req)
//  m0_addr      in   AW  master 0 address
//  m0_wr_data   in   DW  master 0 write data
//  m0_ack       out  1   master 0 transaction complete, 1-cycle pulse
//  m0_rd_data   out  DW  master 0 read data, valid with m0_ack, held until next m0 read ack
//  m1_req/m1_write/m1_addr/m1_wr_data/m1_ack/m1_rd_data   same as m0_*, for master 1
//  int_address  out  AW  register-file address
//  int_wr_data  out  DW  register-file write data
//  int_write    out  1   register-file write strobe, 1 cycle
//  int_read     out  1   register-file read strobe, 1 cycle
//  int_rd_data  in   DW  register-file read data
//  busy         out  1   high in every state except IDLE
//  grant        out  1   index of the master owning the current/last transaction
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE; rr pointer = 1, so master 0 wins the first tie.
//    Reset is asynchronous: asserting it mid-transaction aborts it with no ack and no further strobe.
//  - All outputs are registered; none is combinationally dependent on inputs.
//  - FSM states:
//    IDLE -> ISSUE when any req is high; otherwise stay.
//    ISSUE -> ACK for a write; ISSUE -> WAIT for a read.
//    WAIT -> ACK when the latency counter reaches 0.
//    ACK -> IDLE.
//  - IDLE arbitration:
//    one requester: it wins.
//    both requesting: the master != rr pointer wins.
//    rr pointer <= winner; grant <= winner.
//    Latch the winner's addr, wr_data and write into internal regs.
//  - ISSUE (cycle T):
//    int_address/int_wr_data = latched values;
//    int_write = latched write; int_read = !latched write; exactly one strobe, one cycle.
//    Load the counter with RD_LATENCY-1.
//  - WAIT: decrement the counter each cycle.
//    int_rd_data is captured on the edge ending cycle T+RD_LATENCY.
//  - ACK: the granted master's ack = 1 for one cycle; on a read its rd_data = captured value.
//    The other master's ack and rd_data are untouched.
//  - Latency from the IDLE cycle in which req is sampled:
//    write: ack 2 cycles later (3-cycle transaction).
//    read: ack RD_LATENCY+2 cycles later.
//  - Handshake:
//    req is sampled only in IDLE.
//    A master must drop req in the cycle after it sees ack; req high in the IDLE cycle following ACK is a new request.
//    A req dropped before grant is ignored.
//    A req dropped after grant does not cancel the transaction; ack is still pulsed.
//  - m*_addr/m*_wr_data/m*_write may change after grant; the latched copies are used.
//  - int_address and int_wr_data hold their last values between transactions; strobes are 0 outside ISSUE.
//  - Continuous requests from both masters alternate strictly: 0,1,0,1...
//  - Counter is 4 bits wide; RD_LATENCY outside 1..15 is unsupported.
// TESTING
//  1. m0 write addr=0x1234 data=0xA5 -> int_write=1 for 1 cycle with int_address=0x1234 and int_wr_data=0xA5;
//     m0_ack 2 cycles after req sampled; m1_ack stays 0.
//  2. RD_LATENCY=2; model returns 0x3C at 0x0010; m1 reads 0x0010 -> one int_read pulse;
//     m1_ack 4 cycles after req sampled, with m1_rd_data=0x3C.
//  3. After reset, m0 and m1 request in the same cycle and hold req -> grant order 0,1,0,1;
//     each master gets an ack every 6 cycles (writes).
//  4. m0 alone issues back-to-back writes to 0x0001..0x0004 -> one int_write every 3 cycles; no int_read.
//  5. RD_LATENCY=3; assert reset during WAIT -> all outputs 0 immediately and no ack;
//     after release, an m1 read completes normally with correct data.
//  6. m1 raises req while m0 is in WAIT, then drops it before IDLE -> no m1 transaction;
//     m0 completes unaffected.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: shares the internal register-file bus between master 0
// (UART parser) and master 1 (local controller). The arbitration is round-robin.
// Each granted transaction drives exactly one bus cycle. The granted master
// then receives a single-cycle ack, and on a read it also receives the read data.
//
// Handshake (both masters): a master raises m*_req with m*_write/m*_addr/
// m*_wr_data valid and holds req until it sees m*_ack (1-cycle pulse).
// The arbiter samples req only in IDLE. Command fields are latched at grant.
// After grant the command fields are free to change. Dropping req after
// grant does not cancel the transaction. Dropping req before grant means
// the master is never granted. A req that is high in the IDLE cycle after
// ACK is treated as a new request.
module uart_bus_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_write,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wr_data,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rd_data,
   input  logic          m1_req,
   input  logic          m1_write,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wr_data,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rd_data,
   output logic [AW-1:0] int_address,
   output logic [DW-1:0] int_wr_data,
   output logic          int_write,
   output logic          int_read,
   input  logic [DW-1:0] int_rd_data,
   output logic          busy,
   output logic          grant,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rr_q, rr_d;
   logic          grant_q, grant_d;
   logic          lat_write_q, lat_write_d;
   // The bus address/data registers double as the latched command copy:
   // they are loaded at grant and hold until the next grant.
   logic [AW-1:0] int_address_q, int_address_d;
   logic [DW-1:0] int_wr_data_q, int_wr_data_d;
   logic          int_write_q, int_write_d;
   logic          int_read_q, int_read_d;
   logic          busy_q, busy_d;
   logic          m0_ack_q, m0_ack_d;
   logic          m1_ack_q, m1_ack_d;
   logic [DW-1:0] m0_rd_data_q, m0_rd_data_d;
   logic [DW-1:0] m1_rd_data_q, m1_rd_data_d;

   logic          any_req;
   logic          win;
   logic          win_write;

   // Arbitration: a lone requester wins; on a tie the master not named by rr wins.
   always_comb begin
      any_req   = m0_req | m1_req;
      win       = (m0_req && m1_req) ? ~rr_q : m1_req;
      win_write = win ? m1_write : m0_write;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      lat_write_d   = lat_write_q;
      int_address_d = int_address_q;
      int_wr_data_d = int_wr_data_q;
      int_write_d   = 1'b0;
      int_read_d    = 1'b0;
      m0_ack_d      = 1'b0;
      m1_ack_d      = 1'b0;
      m0_rd_data_d  = m0_rd_data_q;
      m1_rd_data_d  = m1_rd_data_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d       = S_ISSUE;
               rr_d          = win;
               grant_d       = win;
               lat_write_d   = win_write;
               int_address_d = win ? m1_addr : m0_addr;
               int_wr_data_d = win ? m1_wr_data : m0_wr_data;
               // The strobe is registered here so it is high exactly during ISSUE.
               int_write_d   = win_write;
               int_read_d    = ~win_write;
            end
         end
         S_ISSUE: begin
            cnt_d = CNT_LOAD;
            if (lat_write_q) begin
               state_d = S_ACK;
               if (grant_q) m1_ack_d = 1'b1;
               else         m0_ack_d = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               // This edge ends cycle ISSUE+RD_LATENCY, when read data is valid.
               state_d = S_ACK;
               if (grant_q) begin
                  m1_ack_d     = 1'b1;
                  m1_rd_data_d = int_rd_data;
               end else begin
                  m0_ack_d     = 1'b1;
                  m0_rd_data_d = int_rd_data;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         rr_q          <= 1'b1;
         grant_q       <= 1'b0;
         lat_write_q   <= 1'b0;
         int_address_q <= '0;
         int_wr_data_q <= '0;
         int_write_q   <= 1'b0;
         int_read_q    <= 1'b0;
         busy_q        <= 1'b0;
         m0_ack_q      <= 1'b0;
         m1_ack_q      <= 1'b0;
         m0_rd_data_q  <= '0;
         m1_rd_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rr_q          <= rr_d;
         grant_q       <= grant_d;
         lat_write_q   <= lat_write_d;
         int_address_q <= int_address_d;
         int_wr_data_q <= int_wr_data_d;
         int_write_q   <= int_write_d;
         int_read_q    <= int_read_d;
         busy_q        <= busy_d;
         m0_ack_q      <= m0_ack_d;
         m1_ack_q      <= m1_ack_d;
         m0_rd_data_q  <= m0_rd_data_d;
         m1_rd_data_q  <= m1_rd_data_d;
      end
   end

   assign m0_ack      = m0_ack_q;
   assign m0_rd_data  = m0_rd_data_q;
   assign m1_ack      = m1_ack_q;
   assign m1_rd_data  = m1_rd_data_q;
   assign int_address = int_address_q;
   assign int_wr_data = int_wr_data_q;
   assign int_write   = int_write_q;
   assign int_read    = int_read_q;
   assign busy        = busy_q;
   assign grant       = grant_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Testbench for uart_bus_arbiter.
// Two instances share the same stimulus: u2 (RD_LATENCY=2) and u3 (RD_LATENCY=3).
// Each instance has its own register-file model. The model drives valid read
// data only in the cycle RD_LATENCY after int_read. In every other cycle it
// drives 8'hEE, so a capture on the wrong edge returns the wrong value.
module tb_uart_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
   logic [15:0] m0_addr = '0, m1_addr = '0;
   logic [7:0]  m0_wr_data = '0, m1_wr_data = '0;

   logic        a_m0_ack, a_m1_ack, a_int_write, a_int_read, a_busy, a_grant;
   logic [7:0]  a_m0_rd, a_m1_rd, a_int_wd, a_int_rd;
   logic [15:0] a_int_addr;
   logic [1:0]  a_state;
   logic        b_m0_ack, b_m1_ack, b_int_write, b_int_read, b_busy, b_grant;
   logic [7:0]  b_m0_rd, b_m1_rd, b_int_wd, b_int_rd;
   logic [15:0] b_int_addr;
   logic [1:0]  b_state;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   uart_bus_arbiter #(.AW(16), .DW(8), .RD_LATENCY(2)) u2 (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_ack(a_m0_ack), .m0_rd_data(a_m0_rd),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_ack(a_m1_ack), .m1_rd_data(a_m1_rd),
      .int_address(a_int_addr), .int_wr_data(a_int_wd), .int_write(a_int_write),
      .int_read(a_int_read), .int_rd_data(a_int_rd),
      .busy(a_busy), .grant(a_grant), .state_dbg(a_state));

   uart_bus_arbiter #(.AW(16), .DW(8), .RD_LATENCY(3)) u3 (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_ack(b_m0_ack), .m0_rd_data(b_m0_rd),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_ack(b_m1_ack), .m1_rd_data(b_m1_rd),
      .int_address(b_int_addr), .int_wr_data(b_int_wd), .int_write(b_int_write),
      .int_read(b_int_read), .int_rd_data(b_int_rd),
      .busy(b_busy), .grant(b_grant), .state_dbg(b_state));

   // Register-file contents: 0x0010 holds 0x3C, every other address returns addr[7:0]^0x5A.
   function automatic logic [7:0] rf(input logic [15:0] a);
      return (a == 16'h0010) ? 8'h3C : (a[7:0] ^ 8'h5A);
   endfunction

   logic [2:0] sr2, sr3;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         sr2 <= '0;
         sr3 <= '0;
      end else begin
         sr2 <= {sr2[1:0], a_int_read};
         sr3 <= {sr3[1:0], b_int_read};
      end
   end
   assign a_int_rd = sr2[1] ? rf(a_int_addr) : 8'hEE;
   assign b_int_rd = sr3[2] ? rf(b_int_addr) : 8'hEE;

   // Output bundle: {busy, grant, int_write, int_read, int_address, int_wr_data,
   //                 m0_ack, m0_rd_data, m1_ack, m1_rd_data}
   logic [45:0] act2, act3;
   assign act2 = {a_busy, a_grant, a_int_write, a_int_read, a_int_addr, a_int_wd,
                  a_m0_ack, a_m0_rd, a_m1_ack, a_m1_rd};
   assign act3 = {b_busy, b_grant, b_int_write, b_int_read, b_int_addr, b_int_wd,
                  b_m0_ack, b_m0_rd, b_m1_ack, b_m1_rd};

   typedef struct packed {
      logic        m0_req;
      logic        m0_write;
      logic [15:0] m0_addr;
      logic [7:0]  m0_wd;
      logic        m1_req;
      logic        m1_write;
      logic [15:0] m1_addr;
      logic [7:0]  m1_wd;
   } in_t;

   typedef struct {
      in_t         in;
      logic [45:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic in_t mi(input logic r0, input logic w0, input logic [15:0] a0,
                              input logic [7:0] d0, input logic r1, input logic w1,
                              input logic [15:0] a1, input logic [7:0] d1);
      return {r0, w0, a0, d0, r1, w1, a1, d1};
   endfunction

   function automatic logic [45:0] ex(input logic b, input logic g, input logic w,
                                      input logic r, input logic [15:0] a,
                                      input logic [7:0] d, input logic k0,
                                      input logic [7:0] q0, input logic k1,
                                      input logic [7:0] q1);
      return {b, g, w, r, a, d, k0, q0, k1, q1};
   endfunction

   task automatic check(input string nm, input logic [45:0] act, input logic [45:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      m0_req     = v.m0_req;
      m0_write   = v.m0_write;
      m0_addr    = v.m0_addr;
      m0_wr_data = v.m0_wd;
      m1_req     = v.m1_req;
      m1_write   = v.m1_write;
      m1_addr    = v.m1_addr;
      m1_wr_data = v.m1_wd;
   endtask

   // Apply inputs at the falling edge, then sample 1 ns after the rising edge.
   task automatic step(input in_t v);
      @(negedge clock);
      drive(v);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      drive('0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int   ack2, ack3;
      logic [7:0] d2, d3;
      logic w;
      logic [15:0] a;
      logic [7:0] d;

      // Write to m0 at 0x1234, data 0xA5. Only m0_ack is expected to pulse.
      tbl.push_back('{mi(1,1,16'h1234,8'hA5,0,0,0,0), ex(1,0,1,0,16'h1234,8'hA5,0,0,0,0)});
      tbl.push_back('{mi(1,1,16'h1234,8'hA5,0,0,0,0), ex(1,0,0,0,16'h1234,8'hA5,1,0,0,0)});
      tbl.push_back('{mi(0,1,16'h1234,8'hA5,0,0,0,0), ex(0,0,0,0,16'h1234,8'hA5,0,0,0,0)});
      // Read by m1 at 0x0010. With RD_LATENCY=2, ack arrives 4 cycles after sampling and carries 0x3C.
      tbl.push_back('{mi(0,0,0,0,1,0,16'h0010,8'h77), ex(1,1,0,1,16'h0010,8'h77,0,0,0,0)});
      tbl.push_back('{mi(0,0,0,0,1,0,16'h0010,8'h77), ex(1,1,0,0,16'h0010,8'h77,0,0,0,0)});
      tbl.push_back('{mi(0,0,0,0,1,0,16'h0010,8'h77), ex(1,1,0,0,16'h0010,8'h77,0,0,0,0)});
      tbl.push_back('{mi(0,0,0,0,1,0,16'h0010,8'h77), ex(1,1,0,0,16'h0010,8'h77,0,0,1,8'h3C)});
      tbl.push_back('{mi(0,0,0,0,0,0,16'h0010,8'h77), ex(0,1,0,0,16'h0010,8'h77,0,0,0,8'h3C)});
      // m0 reads 0x0030. m1 requests only during WAIT and drops req before IDLE, so m1 is never granted.
      tbl.push_back('{mi(1,0,16'h0030,0,0,0,0,0),          ex(1,0,0,1,16'h0030,0,0,0,0,8'h3C)});
      tbl.push_back('{mi(1,0,16'h0030,0,0,0,0,0),          ex(1,0,0,0,16'h0030,0,0,0,0,8'h3C)});
      tbl.push_back('{mi(1,0,16'h0030,0,1,1,16'h0040,8'h99), ex(1,0,0,0,16'h0030,0,0,0,0,8'h3C)});
      tbl.push_back('{mi(1,0,16'h0030,0,0,1,16'h0040,8'h99), ex(1,0,0,0,16'h0030,0,1,8'h6A,0,8'h3C)});
      tbl.push_back('{mi(0,0,16'h0030,0,0,1,16'h0040,8'h99), ex(0,0,0,0,16'h0030,0,0,8'h6A,0,8'h3C)});
      tbl.push_back('{mi(0,0,16'h0030,0,0,1,16'h0040,8'h99), ex(0,0,0,0,16'h0030,0,0,8'h6A,0,8'h3C)});

      // Reset state
      #12;
      check("reset outputs u2", act2, '0);
      check("reset outputs u3", act3, '0);
      check("reset state u2", 46'(a_state), '0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].in);
         check($sformatf("table vec %0d", i), act2, tbl[i].exp);
      end

      // Both masters hold write requests from reset, so grants must alternate 0,1,0,1.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         w = k[0];
         a = w ? 16'h00B0 : 16'h00A0;
         d = w ? 8'h0B : 8'h0A;
         step(mi(1,1,16'h00A0,8'h0A,1,1,16'h00B0,8'h0B));
         check($sformatf("rr issue %0d", k), act2, ex(1,w,1,0,a,d,0,0,0,0));
         step(mi(1,1,16'h00A0,8'h0A,1,1,16'h00B0,8'h0B));
         check($sformatf("rr ack %0d", k), act2, ex(1,w,0,0,a,d,~w,0,w,0));
         step(mi(1,1,16'h00A0,8'h0A,1,1,16'h00B0,8'h0B));
         check($sformatf("rr idle %0d", k), act2, ex(0,w,0,0,a,d,0,0,0,0));
      end

      // m0 issues back-to-back writes to 0x0001..0x0004: one int_write every 3 cycles and no int_read.
      for (int k = 1; k <= 4; k++) begin
         a = 16'(k);
         d = 8'h10 + 8'(k);
         step(mi(1,1,a,d,0,0,0,0));
         check($sformatf("b2b issue %0d", k), act2, ex(1,0,1,0,a,d,0,0,0,0));
         step(mi(1,1,a,d,0,0,0,0));
         check($sformatf("b2b ack %0d", k), act2, ex(1,0,0,0,a,d,1,0,0,0));
         step(mi(1,1,a,d,0,0,0,0));
         check($sformatf("b2b idle %0d", k), act2, ex(0,0,0,0,a,d,0,0,0,0));
      end

      // Reset asserted during WAIT on u3: outputs clear at once and no ack follows.
      do_reset();
      step(mi(1,0,16'h0020,0,0,0,0,0));
      check("t5 issue u3", act3, ex(1,0,0,1,16'h0020,0,0,0,0,0));
      step(mi(1,0,16'h0020,0,0,0,0,0));
      check("t5 wait u3", act3, ex(1,0,0,0,16'h0020,0,0,0,0,0));
      #1;
      reset = 1'b1;
      m0_req = 1'b0;
      #1;
      check("t5 async clear u3", act3, '0);
      check("t5 async clear u2", act2, '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step('0);
         check($sformatf("t5 quiet %0d", i), act3, '0);
      end
      ack2 = 0;
      ack3 = 0;
      d2   = '0;
      d3   = '0;
      for (int i = 1; i <= 12; i++) begin
         step(mi(0,0,0,0,(ack3 == 0),0,16'h0020,0));
         if (a_m1_ack && ack2 == 0) begin
            ack2 = i;
            d2   = a_m1_rd;
         end
         if (b_m1_ack && ack3 == 0) begin
            ack3 = i;
            d3   = b_m1_rd;
         end
      end
      check("t5 u3 ack latency", 46'(ack3), 46'd5);
      check("t5 u3 rd data", 46'(d3), 46'h7A);
      check("t5 u2 ack latency", 46'(ack2), 46'd4);
      check("t5 u2 rd data", 46'(d2), 46'h7A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
